// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels and the response channel of the
// shared ALU. The master side is the requester/consumer environment; the
// slave side is the arbiter itself.
interface alu_arbiter_if #(
    parameter int WORDSIZE = 32
);
    logic                req0_valid;
    logic                req0_ready;
    logic [WORDSIZE-1:0] req0_a;
    logic [WORDSIZE-1:0] req0_b;
    logic [3:0]          req0_ctl;

    logic                req1_valid;
    logic                req1_ready;
    logic [WORDSIZE-1:0] req1_a;
    logic [WORDSIZE-1:0] req1_b;
    logic [3:0]          req1_ctl;

    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [WORDSIZE-1:0] rsp_r;
    logic                rsp_z;

    logic                busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctl,
        output req1_valid, req1_a, req1_b, req1_ctl,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_z, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctl,
        input  req1_valid, req1_a, req1_b, req1_ctl,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_z, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a single ALU. One operation
// is in flight at a time: IDLE grants and latches operands, EXEC computes
// and registers the result, RESP holds it until the consumer takes it.
module alu_arbiter #(
    parameter int WORDSIZE = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;

    state_t              state;
    state_t              state_next;
    logic                ptr;
    logic                grant0;
    logic                grant1;
    logic                accept;

    // Accept stage: operands captured at the handshake edge
    logic [WORDSIZE-1:0] a_p0;
    logic [WORDSIZE-1:0] b_p0;
    logic [3:0]          ctl_p0;
    logic                id_p0;

    // Result stage: registered at the end of EXEC, held through RESP
    logic [WORDSIZE-1:0] r_p1;
    logic                z_p1;
    logic                id_p1;

    logic [WORDSIZE-1:0] alu_r;

    // Unknown op codes yield zero so the zero flag reads 1 for them.
    function automatic logic [WORDSIZE-1:0] alu_op(
        input logic [3:0]          ctl,
        input logic [WORDSIZE-1:0] a,
        input logic [WORDSIZE-1:0] b
    );
        logic [WORDSIZE-1:0] res;
        case (ctl)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // Arbitration and next-state logic; grants exist only in IDLE
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req0_valid && (!bus.req1_valid || !ptr)) begin
                    grant0 = 1'b1;
                end else if (bus.req1_valid) begin
                    grant1 = 1'b1;
                end
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = grant0 | grant1;

    // State register; reset abandons any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority pointer moves to the requester that lost this grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= grant0;
        end
    end

    // Operand capture at accept; later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0   <= grant1 ? bus.req1_a   : bus.req0_a;
            b_p0   <= grant1 ? bus.req1_b   : bus.req0_b;
            ctl_p0 <= grant1 ? bus.req1_ctl : bus.req0_ctl;
            id_p0  <= grant1;
        end
    end

    assign alu_r = alu_op(ctl_p0, a_p0, b_p0);

    // Result register loaded once in EXEC and held stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1  <= '0;
            z_p1  <= 1'b0;
            id_p1 <= 1'b0;
        end else if (state == EXEC) begin
            r_p1  <= alu_r;
            z_p1  <= (alu_r == '0);
            id_p1 <= id_p0;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_r      = r_p1;
    assign bus.rsp_z      = z_p1;
    assign bus.rsp_id     = id_p1;
    assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter at WORDSIZE = 4: directed scenarios followed by
// randomized traffic scored against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   model_ptr = 1'b0;

    alu_arbiter_if #(.WORDSIZE(W)) bus ();

    alu_arbiter #(.WORDSIZE(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    // Reference ALU from plain integer arithmetic, wrapped to W bits.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] ctl,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int x;
        int m;
        m = 1 << W;
        case (int'(ctl))
            0:       x = int'(a & b);
            1:       x = int'(a | b);
            2:       x = (int'(a) + int'(b)) % m;
            6:       x = (int'(a) - int'(b) + m) % m;
            default: x = 0;
        endcase
        return x[W-1:0];
    endfunction

    function automatic logic [3:0] pick_ctl();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0:       return 4'd0;
            1:       return 4'd1;
            2:       return 4'd2;
            3:       return 4'd6;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic clear_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctl = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctl = '0;
        bus.rsp_ready  = 1'b0;
    endtask

    task automatic randomize_requests(input bit force0);
        bus.req0_valid = force0 ? 1'b1 : 1'($urandom_range(0, 1));
        bus.req1_valid = 1'($urandom_range(0, 1));
        bus.req0_a = W'($urandom); bus.req0_b = W'($urandom); bus.req0_ctl = pick_ctl();
        bus.req1_a = W'($urandom); bus.req1_b = W'($urandom); bus.req1_ctl = pick_ctl();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=0000",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy});
        end
        checks++;
        if ({bus.rsp_r, bus.rsp_z, bus.rsp_id} !== 6'b0) begin
            failures++;
            $display("FAIL reset_data got=%b required=000000", {bus.rsp_r, bus.rsp_z, bus.rsp_id});
        end
        // Bring an op to RESP, then pull reset between clock edges
        bus.req0_valid = 1'b1; bus.req0_ctl = 4'd2; bus.req0_a = 4'd3; bus.req0_b = 4'd4;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_r !== 4'd7) begin
            failures++;
            $display("FAIL pre_reset_resp got=%b/%0d required=1/7", bus.rsp_valid, bus.rsp_r);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.rsp_r, bus.rsp_z, bus.rsp_id} !== 8'b0) begin
            failures++;
            $display("FAIL async_reset got=%b required=00000000",
                     {bus.rsp_valid, bus.busy, bus.rsp_r, bus.rsp_z, bus.rsp_id});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL post_reset_idle got=%b required=000",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid});
        end
    endtask

    task automatic test_single_op();
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_ctl = 4'd2; bus.req0_a = 4'd7; bus.req0_b = 4'd5;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_ready got=%b required=10", {bus.req0_ready, bus.req1_ready});
        end
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req0_a = 4'hF; bus.req0_ctl = 4'd6;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy} !== 4'b0001) begin
            failures++;
            $display("FAIL single_exec got=%b required=0001",
                     {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy});
        end
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id} !== {1'b1, 4'd12, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL single_resp got=v%b r%0d z%b id%b required=v1 r12 z0 id0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id);
        end
        model_ptr = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_done got=%b required=00", {bus.rsp_valid, bus.busy});
        end
    endtask

    task automatic test_contention();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        for (int round = 0; round < 2; round++) begin
            bus.rsp_ready = 1'b1;
            bus.req0_valid = 1'b1; bus.req0_ctl = 4'd0; bus.req0_a = 4'd3; bus.req0_b = 4'd2;
            bus.req1_valid = 1'b1; bus.req1_ctl = 4'd1; bus.req1_a = 4'd1; bus.req1_b = 4'd4;
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
                failures++;
                $display("FAIL contend_first r%0d got=%b required=10", round, {bus.req0_ready, bus.req1_ready});
            end
            @(negedge clk);
            bus.req0_valid = 1'b0;
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
                failures++;
                $display("FAIL contend_exec_ready r%0d got=%b required=00", round, {bus.req0_ready, bus.req1_ready});
            end
            @(negedge clk); #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_r, bus.rsp_id} !== {1'b1, 4'd2, 1'b0}) begin
                failures++;
                $display("FAIL contend_resp0 r%0d got=v%b r%0d id%b required=v1 r2 id0",
                         round, bus.rsp_valid, bus.rsp_r, bus.rsp_id);
            end
            @(negedge clk); #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
                failures++;
                $display("FAIL contend_second r%0d got=%b required=01", round, {bus.req0_ready, bus.req1_ready});
            end
            @(negedge clk);
            bus.req1_valid = 1'b0;
            @(negedge clk); #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id} !== {1'b1, 4'd5, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL contend_resp1 r%0d got=v%b r%0d z%b id%b required=v1 r5 z0 id1",
                         round, bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id);
            end
            @(negedge clk); #1;
        end
        model_ptr = 1'b0;
    endtask

    task automatic test_backpressure_zero();
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_ctl = 4'd6; bus.req1_a = 4'd5; bus.req1_b = 4'd5;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_accept got=%b required=01", {bus.req0_ready, bus.req1_ready});
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_ctl = 4'd2; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id, bus.req0_ready, bus.req1_ready}
                    !== {1'b1, 4'd0, 1'b1, 1'b1, 2'b00}) begin
                failures++;
                $display("FAIL bp_hold c%0d got=v%b r%0d z%b id%b rdy%b%b required=v1 r0 z1 id1 rdy00",
                         c, bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id, bus.req0_ready, bus.req1_ready);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.req0_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got=%b required=01", {bus.rsp_valid, bus.req0_ready});
        end
        // Requester withdraws before the edge: nothing may be accepted
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL withdraw got=%b required=00", {bus.busy, bus.rsp_valid});
        end
        model_ptr = 1'b0;
    endtask

    task automatic test_wrap_illegal();
        logic [3:0]   ctls [3];
        logic [W-1:0] as [3];
        logic [W-1:0] bs [3];
        logic [W-1:0] rs [3];
        logic         zs [3];
        ctls = '{4'd2, 4'd6, 4'd5};
        as   = '{4'd9, 4'd2, 4'd7};
        bs   = '{4'd8, 4'd5, 4'd3};
        rs   = '{4'd1, 4'd13, 4'd0};
        zs   = '{1'b0, 1'b0, 1'b1};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1'b1; bus.req0_ctl = ctls[i]; bus.req0_a = as[i]; bus.req0_b = bs[i];
            @(negedge clk);
            bus.req0_valid = 1'b0;
            @(negedge clk); #1;
            checks++;
            if ({bus.rsp_valid, bus.rsp_r, bus.rsp_z} !== {1'b1, rs[i], zs[i]}) begin
                failures++;
                $display("FAIL wrap_illegal i%0d got=v%b r%0d z%b required=v1 r%0d z%b",
                         i, bus.rsp_valid, bus.rsp_r, bus.rsp_z, rs[i], zs[i]);
            end
            @(negedge clk); #1;
        end
        model_ptr = 1'b1;
    endtask

    task automatic test_reset_in_exec();
        bus.rsp_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_ctl = 4'd2; bus.req1_a = 4'd2; bus.req1_b = 4'd3;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL exec_reset got=%b required=00", {bus.busy, bus.rsp_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                failures++;
                $display("FAIL discarded c%0d got=%b required=00", c, {bus.rsp_valid, bus.busy});
            end
        end
        // Both requesting: requester 0 must win right after reset
        bus.req0_valid = 1'b1; bus.req0_ctl = 4'd1; bus.req0_a = 4'd8; bus.req0_b = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_ctl = 4'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL post_reset_prio got=%b required=10", {bus.req0_ready, bus.req1_ready});
        end
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.rsp_r, bus.rsp_id} !== {1'b1, 4'd9, 1'b0}) begin
            failures++;
            $display("FAIL post_reset_op got=v%b r%0d id%b required=v1 r9 id0",
                     bus.rsp_valid, bus.rsp_r, bus.rsp_id);
        end
        @(negedge clk); #1;
        model_ptr = 1'b1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            int           win;
            logic [W-1:0] exp_r;
            logic         exp_z;
            logic         exp_id;
            bit           taken;
            int           cycles;
            win = -1;
            for (int g = 0; g < 16 && win < 0; g++) begin
                randomize_requests(g == 15);
                if (bus.req0_valid && bus.req1_valid) win = int'(model_ptr);
                else if (bus.req0_valid) win = 0;
                else if (bus.req1_valid) win = 1;
                #1;
                checks++;
                if ({bus.req0_ready, bus.req1_ready} !== {win == 0, win == 1}) begin
                    failures++;
                    $display("FAIL rand_grant t%0d got=%b required=%b", t,
                             {bus.req0_ready, bus.req1_ready}, {win == 0, win == 1});
                end
                if (win < 0) @(negedge clk);
            end
            exp_r  = (win == 1) ? ref_alu(bus.req1_ctl, bus.req1_a, bus.req1_b)
                                : ref_alu(bus.req0_ctl, bus.req0_a, bus.req0_b);
            exp_z  = (exp_r == 0);
            exp_id = (win == 1);
            model_ptr = (win == 0);
            @(negedge clk);
            randomize_requests(1'b0);
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy} !== 4'b0001) begin
                failures++;
                $display("FAIL rand_exec t%0d got=%b required=0001", t,
                         {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.busy});
            end
            @(negedge clk);
            cycles = 0;
            taken  = 1'b0;
            while (!taken) begin
                #1;
                checks++;
                if ({bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id, bus.req0_ready, bus.req1_ready}
                        !== {1'b1, exp_r, exp_z, exp_id, 2'b00}) begin
                    failures++;
                    $display("FAIL rand_resp t%0d got=v%b r%0d z%b id%b rdy%b%b required=v1 r%0d z%b id%b rdy00",
                             t, bus.rsp_valid, bus.rsp_r, bus.rsp_z, bus.rsp_id,
                             bus.req0_ready, bus.req1_ready, exp_r, exp_z, exp_id);
                end
                bus.rsp_ready = (cycles >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                randomize_requests(1'b0);
                taken = bus.rsp_ready;
                cycles++;
                @(negedge clk);
            end
            #1;
            checks++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                failures++;
                $display("FAIL rand_done t%0d got=%b required=00", t, {bus.rsp_valid, bus.busy});
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure_zero();
        test_wrap_illegal();
        test_reset_in_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
